// File: rtl/tpu_command_assembler.sv
// ============================================================================
// Module   : tpu_command_assembler
// Brief    : Collects opcode/payload bytes from a byte stream, packs them into
//            a 48-bit TPU command and issues it with a one-cycle execute
//            strobe, holding the word stable while the TPU is busy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef TPU_CLEARSCREEN
`define TPU_CLEARSCREEN 8'h01
`endif
`ifndef TPU_PRINT
`define TPU_PRINT       8'h02
`endif
`ifndef TPU_LOCATE
`define TPU_LOCATE      8'h03
`endif
`ifndef TPU_SETATTR
`define TPU_SETATTR     8'h04
`endif
`ifndef TPU_SETMASK
`define TPU_SETMASK     8'h05
`endif

module tpu_command_assembler #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        tpu_execute,
   output logic [47:0] tpu_command,
   input  logic        tpu_busy,
   output logic [7:0]  err_count,
   output logic        idle
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COLLECT   = 3'd1,
      ISSUE     = 3'd2,
      WAIT_ACK  = 3'd3,
      WAIT_DONE = 3'd4
   } state_t;

   localparam logic [23:0] C_TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;

   state_t      state_q, state_d;
   logic [1:0]  remaining_q, remaining_d;
   logic [1:0]  slot_q, slot_d;
   logic [23:0] timer_q, timer_d;
   logic [47:0] cmd_q, cmd_d;
   logic [7:0]  err_q, err_d;

   logic        w_accept;
   logic        w_err_inc;
   logic        w_known;
   logic [1:0]  w_payload_len;

   assign byte_ready  = ((state_q == IDLE) || (state_q == COLLECT)) && !reset;
   assign w_accept    = byte_valid && byte_ready;
   assign tpu_execute = (state_q == ISSUE);
   assign tpu_command = cmd_q;
   assign err_count   = err_q;
   assign idle        = (state_q == IDLE);

   // Opcode decode: payload byte count following the opcode.
   always_comb begin
      w_known       = 1'b1;
      w_payload_len = 2'd0;
      case (byte_data)
         `TPU_CLEARSCREEN: w_payload_len = 2'd0;
         `TPU_PRINT:       w_payload_len = 2'd1;
         `TPU_LOCATE:      w_payload_len = 2'd2;
         `TPU_SETATTR:     w_payload_len = 2'd2;
         `TPU_SETMASK:     w_payload_len = 2'd3;
         default:          w_known       = 1'b0;
      endcase
   end

   // Next-state logic for the command FSM and its datapath registers.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      slot_d      = slot_q;
      timer_d     = timer_q;
      cmd_d       = cmd_q;
      w_err_inc   = 1'b0;

      case (state_q)
         IDLE: begin
            if (w_accept) begin
               if (w_known) begin
                  cmd_d       = {40'h0, byte_data};
                  remaining_d = w_payload_len;
                  slot_d      = 2'd1;
                  timer_d     = 24'd0;
                  state_d     = (w_payload_len == 2'd0) ? ISSUE : COLLECT;
               end else begin
                  w_err_inc = 1'b1;
               end
            end
         end
         COLLECT: begin
            // An arriving byte beats a timeout firing in the same cycle.
            if (w_accept) begin
               cmd_d[{slot_q, 3'b000} +: 8] = byte_data;
               remaining_d = remaining_q - 2'd1;
               slot_d      = slot_q + 2'd1;
               timer_d     = 24'd0;
               if (remaining_q == 2'd1) begin
                  state_d = ISSUE;
               end
            end else if (timer_q == C_TIMEOUT_LAST) begin
               w_err_inc   = 1'b1;
               timer_d     = 24'd0;
               remaining_d = 2'd0;
               slot_d      = 2'd0;
               state_d     = IDLE;
            end else begin
               timer_d = timer_q + 24'd1;
            end
         end
         ISSUE: begin
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            // The TPU raises busy on the edge it samples execute; skip it.
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!tpu_busy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      err_d = err_q;
      if (w_err_inc && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= 2'd0;
         slot_q      <= 2'd0;
         timer_q     <= 24'd0;
         cmd_q       <= 48'h0;
         err_q       <= 8'h00;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         slot_q      <= slot_d;
         timer_q     <= timer_d;
         cmd_q       <= cmd_d;
         err_q       <= err_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tpu_command_assembler.sv
// ============================================================================
// Module   : tb_tpu_command_assembler
// Brief    : Directed self-checking bench for tpu_command_assembler with a
//            small TPU busy model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef TPU_CLEARSCREEN
`define TPU_CLEARSCREEN 8'h01
`endif
`ifndef TPU_PRINT
`define TPU_PRINT       8'h02
`endif
`ifndef TPU_LOCATE
`define TPU_LOCATE      8'h03
`endif
`ifndef TPU_SETATTR
`define TPU_SETATTR     8'h04
`endif
`ifndef TPU_SETMASK
`define TPU_SETMASK     8'h05
`endif

module tb_tpu_command_assembler;

   logic        clk;
   logic        reset;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        tpu_execute;
   logic [47:0] tpu_command;
   logic        tpu_busy;
   logic [7:0]  err_count;
   logic        idle;

   int          checks;
   int          errors;
   int          exec_cnt;
   int          ready_while_busy;
   int          busy_len;
   logic [15:0] busy_cnt;

   tpu_command_assembler #(.TIMEOUT_CYCLES(24'd16)) dut (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .tpu_execute(tpu_execute),
      .tpu_command(tpu_command),
      .tpu_busy   (tpu_busy),
      .err_count  (err_count),
      .idle       (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // TPU model: busy rises on the edge execute is sampled, lasts busy_len cycles.
   always @(posedge clk) begin
      if (reset) busy_cnt <= 16'd0;
      else if (tpu_execute) busy_cnt <= busy_len[15:0];
      else if (busy_cnt != 16'd0) busy_cnt <= busy_cnt - 16'd1;
   end
   assign tpu_busy = (busy_cnt != 16'd0);

   // Protocol monitors.
   always @(posedge clk) begin
      if (tpu_execute) exec_cnt <= exec_cnt + 1;
      if (tpu_busy && byte_ready) ready_while_busy <= ready_while_busy + 1;
   end

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Offer a byte and hold it until accepted; returns the stall cycle count.
   task automatic send_byte(input logic [7:0] b, output int stalls);
      stalls = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && stalls < 5000) begin
         @(posedge clk); #1;
         stalls++;
      end
      if (!byte_ready) begin
         check("accept_timeout", 48'd0, 48'd1);
      end else begin
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!idle && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, {47'd0, idle}, 48'd1);
   endtask

   initial begin
      int s, n, bad, e0;
      logic [47:0] exp_cmd;
      checks = 0; errors = 0; exec_cnt = 0; ready_while_busy = 0;
      busy_len = 3;
      reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",   {47'd0, byte_ready},  48'd0);
      check("rst_execute", {47'd0, tpu_execute}, 48'd0);
      check("rst_command", tpu_command,          48'h0);
      check("rst_err",     {40'd0, err_count},   48'd0);
      check("rst_idle",    {47'd0, idle},        48'd1);
      reset = 1'b0;
      #1;
      check("ready_after_rst", {47'd0, byte_ready}, 48'd1);

      // PRINT 0x41, TPU busy 3 cycles.
      send_byte(`TPU_PRINT, s);
      send_byte(8'h41, s);
      check("print_stall", s, 0);
      exp_cmd = {32'h0, 8'h41, `TPU_PRINT};
      check("print_exec", {47'd0, tpu_execute}, 48'd1);
      check("print_cmd",  tpu_command, exp_cmd);
      bad = 0; n = 0;
      while (!idle && n < 50) begin
         @(posedge clk); #1;
         n++;
         if (!idle && (byte_ready || tpu_command !== exp_cmd)) bad++;
      end
      check("print_hold",      bad, 0);
      check("print_to_idle",   n, 5);
      check("print_cmd_after", tpu_command, exp_cmd);
      check("print_exec_cnt",  exec_cnt, 1);

      // SETMASK FF 00 AA.
      send_byte(`TPU_SETMASK, s);
      send_byte(8'hFF, s);
      send_byte(8'h00, s);
      send_byte(8'hAA, s);
      check("mask_exec", {47'd0, tpu_execute}, 48'd1);
      check("mask_cmd",  tpu_command, 48'h0000_AA00_FF05);
      wait_idle("mask_idle");

      // CLEARSCREEN with a long busy period; a PRINT is held waiting.
      busy_len = 2000;
      e0 = exec_cnt;
      send_byte(`TPU_CLEARSCREEN, s);
      check("clr_exec", {47'd0, tpu_execute}, 48'd1);
      check("clr_cmd",  tpu_command, 48'h0000_0000_0001);
      @(posedge clk); #1;
      busy_len = 3;
      send_byte(`TPU_PRINT, s);
      check("clr_stall",    s, 2001);
      check("clr_one_exec", exec_cnt - e0, 1);
      send_byte(8'h00, s);
      check("clr_print_cmd", tpu_command, 48'h0000_0000_0002);
      wait_idle("clr_idle");

      // Timeout on a partial LOCATE, then a full LOCATE.
      e0 = exec_cnt;
      send_byte(`TPU_LOCATE, s);
      send_byte(8'h05, s);
      repeat (20) @(posedge clk);
      #1;
      check("to_err",     {40'd0, err_count}, 48'd1);
      check("to_idle",    {47'd0, idle},      48'd1);
      check("to_no_exec", exec_cnt - e0, 0);
      send_byte(`TPU_LOCATE, s);
      send_byte(8'h01, s);
      send_byte(8'h02, s);
      check("loc_exec", {47'd0, tpu_execute}, 48'd1);
      check("loc_cmd",  tpu_command, 48'h0000_0002_0103);
      wait_idle("loc_idle");

      // Unknown opcode 300 times: saturating error count.
      e0 = exec_cnt; bad = 0;
      for (int i = 0; i < 300; i++) begin
         send_byte(8'hEE, s);
         if (!byte_ready || s != 0) bad++;
      end
      check("unk_ready",   bad, 0);
      check("unk_err_sat", {40'd0, err_count}, 48'hFF);
      check("unk_no_exec", exec_cnt - e0, 0);
      check("unk_idle",    {47'd0, idle}, 48'd1);

      // Reset mid SETMASK, then a fresh PRINT.
      send_byte(`TPU_SETMASK, s);
      send_byte(8'hFF, s);
      reset = 1'b1;
      #1;
      check("mid_rst_ready", {47'd0, byte_ready}, 48'd0);
      @(posedge clk); #1;
      check("mid_rst_cmd",  tpu_command,        48'h0);
      check("mid_rst_err",  {40'd0, err_count}, 48'd0);
      check("mid_rst_idle", {47'd0, idle},      48'd1);
      check("mid_rst_exec", {47'd0, tpu_execute}, 48'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("mid_rst_ready_after", {47'd0, byte_ready}, 48'd1);
      send_byte(`TPU_PRINT, s);
      send_byte(8'h7E, s);
      check("post_rst_exec", {47'd0, tpu_execute}, 48'd1);
      check("post_rst_cmd",  tpu_command, 48'h0000_0000_7E02);
      wait_idle("post_rst_idle");
      check("ready_while_busy", ready_while_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tpu_command_assembler.md
# tpu_command_assembler

Byte-stream front end for the text processing unit. It collects opcode and payload bytes from a byte source (UART receiver, host bridge), assembles them into 48-bit TPU commands, and issues each one with a single-cycle `execute` pulse. While the TPU reports `busy`, it holds the command word stable. It is the initiator side of the TPU `execute`/`command`/`busy` interface and sits between the host link and the TPU.

## Interface
- TIMEOUT_CYCLES, default 24'd1000000: number of idle cycles after which a partial command is discarded. Valid range is 2 to 2^24-1.
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  incoming stream byte
- byte_ready  out  1  assembler can accept a byte this cycle
- tpu_execute  out  1  one-cycle command strobe to the TPU
- tpu_command  out  48  assembled command word
- tpu_busy  in  1  TPU busy flag
- err_count  out  8  saturating count of rejected opcodes and timeouts
- idle  out  1  high when the state is IDLE

## Operation
- Opcodes come from the `TPU_*` macros in constant.vh. Total command length, including the opcode byte:
  - CLEARSCREEN: 1 byte
  - PRINT: 2 bytes
  - LOCATE: 3 bytes
  - SETATTR: 3 bytes
  - SETMASK: 4 bytes
- Command word packing:
  - tpu_command[7:0] = opcode
  - [15:8] = payload byte 1
  - [23:16] = payload byte 2
  - [31:24] = payload byte 3
  - Unused bytes and [47:32] are 0.
- A byte is accepted on a rising edge where byte_valid && byte_ready.
- byte_ready is combinational: (state==IDLE || state==COLLECT) && !reset.
- States:
  - IDLE: on an accepted known opcode, clear tpu_command[47:8] and load [7:0]. For CLEARSCREEN go to ISSUE; otherwise load remaining = length-1 and go to COLLECT. On an unknown opcode, drop the byte, increment err_count and stay in IDLE.
  - COLLECT: each accepted byte is written to the next payload slot and remaining is decremented. When the last payload byte is accepted, go to ISSUE. The timeout counter clears on every accepted byte. If it reaches TIMEOUT_CYCLES-1 with no byte, discard the partial command, increment err_count and go to IDLE.
  - ISSUE: tpu_execute=1 for exactly this cycle, then go to WAIT_ACK.
  - WAIT_ACK: one cycle with tpu_busy ignored, because the TPU raises busy on the edge where it samples execute. Then go to WAIT_DONE.
  - WAIT_DONE: stay while tpu_busy=1. When tpu_busy is sampled 0, go to IDLE.
- tpu_command is held constant from ISSUE until the next opcode is accepted. The TPU reads payload bits in later states of the same command, so this hold is required.
- err_count saturates at 8'hFF.
- Reset mid-command discards all partial state. The TPU is expected to be reset by the same signal.

## Timing
- Reset values:
  - tpu_execute=0
  - tpu_command=48'h0
  - err_count=0
  - state=IDLE, so idle=1
  - timeout counter=0, remaining=0
  - byte_ready=0 while reset is high and 1 the cycle after.
- Latency: if the final byte of a command is accepted at edge k, tpu_execute is high between edges k and k+1.
- Minimum spacing between tpu_execute pulses is 4 cycles, for a CLEARSCREEN with a TPU busy for a single cycle.
- byte_ready is 0 throughout ISSUE, WAIT_ACK and WAIT_DONE. Bytes offered then are not consumed; the source must hold them.
- Back-to-back bytes in COLLECT are accepted every cycle with no gap.
- A byte accepted in the same cycle the timeout would fire wins: the counter clears and no timeout occurs.
- If tpu_busy is already 0 in WAIT_DONE, IDLE is entered on the next edge.

## Test plan
- Send `TPU_PRINT, 8'h41 on consecutive cycles, with the TPU model busy for 3 cycles.
  - Required: one execute pulse one cycle after 8'h41 is accepted, with tpu_command=48'h0000_0000_41_<PRINT>.
  - Required: byte_ready=0 until busy drops, command stable throughout.
- Send `TPU_SETMASK, 8'hFF, 8'h00, 8'hAA.
  - Required: tpu_command[31:8]=24'hAA00FF and [47:32]=0.
- Send `TPU_CLEARSCREEN while the TPU model stays busy for 2000 cycles.
  - Required: single execute pulse, no further pulses, byte_valid stalls for the full 2000 cycles, then IDLE.
- With TIMEOUT_CYCLES=16, send `TPU_LOCATE, 8'h05, then nothing for 20 cycles, then `TPU_LOCATE, 8'h01, 8'h02.
  - Required: err_count=1, no execute for the first command, and tpu_command[23:8]=16'h0201 for the second.
- Send an unknown opcode 300 times.
  - Required: no execute, byte_ready stays 1, err_count saturates at 8'hFF.
- Assert reset after the second byte of SETMASK, then send a fresh PRINT.
  - Required: all outputs at reset values, and the next PRINT is assembled correctly with no residue from SETMASK.
